// File: rtl/stream_packer.sv
// stream_packer: packs RATIO consecutive IN_WIDTH-bit beats into one
// IN_WIDTH*RATIO-bit word, first beat in lane 0. Registered output stage with
// valid/ready handshake; a new word can load in the same cycle the held word
// is taken, so the sustained rate is one beat per cycle.
// Optional feature: define STREAM_PACKER_FLUSH_ON_LAST_EN to let a beat with
// in_last close a partial word (out_keep marks the filled lanes).
module stream_packer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IN_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]          out_keep,
  output logic                      out_last
);

  localparam int OW = IN_WIDTH * RATIO;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0]    cnt;
  logic [OW-1:0]    lanes;
  logic [OW-1:0]    word_next;
  logic [RATIO-1:0] keep_next;
  logic             accept;
  logic             complete;

  // Stall upstream only while a held word has not been taken.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef STREAM_PACKER_FLUSH_ON_LAST_EN
  assign complete = accept && ((cnt == LAST_LANE) || in_last);
`else
  assign complete = accept && (cnt == LAST_LANE);
`endif

  // Current lane storage with the incoming beat merged into lane cnt; lanes
  // above cnt are still zero, so a flushed partial word needs no masking.
  always_comb begin
    word_next = lanes;
    keep_next = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (CW'(k) == cnt) word_next[k*IN_WIDTH +: IN_WIDTH] = in_data;
`ifdef STREAM_PACKER_FLUSH_ON_LAST_EN
      if (CW'(k) <= cnt) keep_next[k] = 1'b1;
`endif
    end
`ifndef STREAM_PACKER_FLUSH_ON_LAST_EN
    keep_next = '1;
`endif
  end

  // Lane counter and partial-word storage; cleared whenever a word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      lanes <= '0;
    end else if (complete) begin
      cnt   <= '0;
      lanes <= '0;
    end else if (accept) begin
      cnt   <= cnt + 1'b1;
      lanes <= word_next;
    end
  end

  // Output register: load on completion (even while the old word is being
  // taken), drop valid on a transfer without a replacement, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= word_next;
      out_keep  <= keep_next;
      out_last  <= in_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Testbench for stream_packer (IN_WIDTH=8, RATIO=4): directed scenarios plus
// randomized traffic scored against a queue-based packing model.
module tb_stream_packer;

  localparam int W = 8;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W*R-1:0] out_data;
  logic [R-1:0]   out_keep;
  logic           out_last;

  stream_packer #(.IN_WIDTH(W), .RATIO(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted beats collect in pend; a finished word is queued
  // in exp_q until the bench sees it handed over downstream.
  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } word_t;
  logic [W-1:0] pend[$];
  word_t        exp_q[$];
  bit           expect_valid = 0;
  bit           prev_stall = 0;
  logic [31:0]  prev_data;
  logic [3:0]   prev_keep;
  logic         prev_last;

`ifdef STREAM_PACKER_FLUSH_ON_LAST_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    expect_valid = 0;
    prev_stall = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, score the cycle, then
  // let the rising edge happen and return just after it.
  task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit ordy);
    word_t w;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
    if (expect_valid) check("latency", 32'(out_valid), 32'd1);
    expect_valid = 0;
    check("valid_vs_model", 32'(out_valid), 32'(exp_q.size() != 0));
    if (prev_stall) begin
      check("hold_data", out_data, prev_data);
      check("hold_keep", 32'(out_keep), 32'(prev_keep));
      check("hold_last", 32'(out_last), 32'(prev_last));
    end
    if (out_valid && out_ready && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      check("word_data", out_data, w.data);
      check("word_keep", 32'(out_keep), 32'(w.keep));
      check("word_last", 32'(out_last), 32'(w.last));
    end
    if (in_valid && in_ready) begin
      pend.push_back(in_data);
      if (pend.size() == R || (FLUSH && in_last)) begin
        w.data = '0;
        foreach (pend[k]) w.data = w.data | (32'(pend[k]) << (8 * k));
        w.keep = FLUSH ? 4'((1 << pend.size()) - 1) : 4'hF;
        w.last = in_last;
        exp_q.push_back(w);
        pend.delete();
        expect_valid = 1;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data; prev_keep = out_keep; prev_last = out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    in_valid = 0; in_last = 0; out_ready = 0;
    rst_n = 0;
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_keep", 32'(out_keep), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    reset_pulse();

    // Four beats form one full word, visible for exactly one cycle.
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_data", out_data, 32'h44332211);
    check("basic_keep", 32'(out_keep), 32'hF);
    step(0, 8'h00, 0, 1);
    check("basic_one_cycle", 32'(out_valid), 32'd0);

    // Backpressure: word held for 5 cycles with in_ready low.
    step(1, 8'hA1, 0, 1); step(1, 8'hA2, 0, 1); step(1, 8'hA3, 0, 1); step(1, 8'hA4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, 32'hA4A3A2A1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    step(0, 8'h00, 0, 1);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_valid", 32'(out_valid), 32'd0);

    // Eight back-to-back beats at full rate.
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0, 1);
      if (i == 4) check("b2b_word0", out_data, 32'h04030201);
      if (i == 8) check("b2b_word1", out_data, 32'h08070605);
    end
    step(0, 8'h00, 0, 1);

    // in_last handling.
    step(1, 8'hAA, 0, 1); step(1, 8'hBB, 1, 1);
    if (FLUSH) begin
      check("flush_valid", 32'(out_valid), 32'd1);
      check("flush_data", out_data, 32'h0000BBAA);
      check("flush_keep", 32'(out_keep), 32'h3);
      check("flush_last", 32'(out_last), 32'd1);
    end else begin
      check("nolast_valid", 32'(out_valid), 32'd0);
      step(1, 8'hCC, 0, 1); step(1, 8'hDD, 0, 1);
      check("nolast_data", out_data, 32'hDDCCBBAA);
      check("nolast_keep", 32'(out_keep), 32'hF);
      check("nolast_last", 32'(out_last), 32'd0);
    end
    step(0, 8'h00, 0, 1);

    // Reset in the middle of a word discards the partial beats.
    step(1, 8'h55, 0, 1); step(1, 8'h66, 0, 1);
    reset_pulse();
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    check("post_rst_data", out_data, 32'h44332211);
    step(0, 8'h00, 0, 1);

    // Randomized traffic with random backpressure and packet ends.
    for (int i = 0; i < 800; i++)
      step($urandom_range(99) < 70, 8'($urandom), $urandom_range(99) < 20,
           $urandom_range(99) < 65);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
